// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline hazard, flush and memory-wait stall sequencer
module hazard_stall_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             dmem_busy,
  input  logic             clr_counts,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // WAIT_FLUSH doubles as the "flush pending" flag: a taken branch seen while
  // memory was busy is remembered here and replayed on the first free cycle.
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT       = 2'd1,
    ST_WAIT_FLUSH = 2'd2,
    ST_UNUSED     = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic load_use;
  logic [CNT_W-1:0] cnt_max;

  assign cnt_max = {CNT_W{1'b1}};

  // A load in ID/EX writing a register the ID instruction reads; r0 never hazards.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Next-state and stage controls; busy freeze beats branch flush beats load-use.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    exmem_bubble = 1'b0;
    state_d      = state_q;

    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (dmem_busy) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          state_d     = mem_branch_taken ? ST_WAIT_FLUSH : ST_WAIT;
        end else begin
          state_d = ST_RUN;
          if (mem_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
          end else if (load_use) begin
            // One bubble suffices: the load reaches MEM next cycle.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
      end
      ST_WAIT_FLUSH: begin
        if (dmem_busy) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
        end else begin
          ifid_flush   = 1'b1;
          idex_bubble  = 1'b1;
          exmem_bubble = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating performance counters for stalled and flushed cycles.
  always_ff @(posedge clk) begin
    if (reset || clr_counts) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != cnt_max)) begin
        stall_count <= stall_count + 1'b1;
      end
      if (ifid_flush && (flush_count != cnt_max)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        mem_branch_taken;
  logic        dmem_busy;
  logic        clr_counts;

  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble;
  logic [1:0]  state;
  logic [15:0] stall_count, flush_count;

  logic        pc_write4, ifid_write4, ifid_flush4, idex_write4, idex_bubble4, exmem_write4, exmem_bubble4;
  logic [1:0]  state4;
  logic [3:0]  stall_count4, flush_count4;

  int checks;
  int errors;

  hazard_stall_controller #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .dmem_busy(dmem_busy), .clr_counts(clr_counts),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
    .exmem_bubble(exmem_bubble), .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_stall_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .dmem_busy(dmem_busy), .clr_counts(clr_counts),
    .pc_write(pc_write4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
    .idex_write(idex_write4), .idex_bubble(idex_bubble4), .exmem_write(exmem_write4),
    .exmem_bubble(exmem_bubble4), .state(state4), .stall_count(stall_count4), .flush_count(flush_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_rt = 5'd0; mem_branch_taken = 1'b0; dmem_busy = 1'b0; clr_counts = 1'b0;
    #1;
  endtask

  task automatic clear_counts();
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL reset_state: state=%0d stall=%0d flush=%0d required 0/0/0", state, stall_count, flush_count);
    end
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble} !== 7'b1101010) begin
      errors++; $display("FAIL reset_defaults: ctrl=%b required 1101010",
        {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble});
    end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble} !== 7'b0001110) begin
      errors++; $display("FAIL load_use_ctrl: ctrl=%b required 0001110",
        {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble});
    end
    step();
    checks++;
    if (stall_count !== 16'd1 || state !== 2'd0) begin
      errors++; $display("FAIL load_use_count: stall=%0d state=%0d required 1/0", stall_count, state);
    end
    ex_rt = 5'd0; id_rs = 5'd0; #1;
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++; $display("FAIL load_use_r0: pc_write=%b idex_bubble=%b required 1/0", pc_write, idex_bubble);
    end
    step();
    ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0; #1;
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++; $display("FAIL load_use_rt_unused: pc_write=%b idex_bubble=%b required 1/0", pc_write, idex_bubble);
    end
    id_uses_rt = 1'b1; #1;
    checks++;
    if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++; $display("FAIL load_use_rt_used: pc_write=%b idex_bubble=%b required 0/1", pc_write, idex_bubble);
    end
    step();
    checks++;
    if (stall_count !== 16'd2) begin
      errors++; $display("FAIL load_use_count2: stall=%0d required 2", stall_count);
    end
  endtask

  task automatic test_branch();
    mem_branch_taken = 1'b1; #1;
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble} !== 7'b1111111) begin
      errors++; $display("FAIL branch_ctrl: ctrl=%b required 1111111",
        {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble});
    end
    step();
    checks++;
    if (flush_count !== 16'd1 || stall_count !== 16'd2 || state !== 2'd0) begin
      errors++; $display("FAIL branch_count: flush=%0d stall=%0d state=%0d required 1/2/0", flush_count, stall_count, state);
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    clear_counts();
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL clr_counts: stall=%0d flush=%0d required 0/0", stall_count, flush_count);
    end
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble} !== 7'b0000000) begin
        errors++; $display("FAIL wait_freeze_%0d: ctrl=%b required 0000000", i,
          {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble});
      end
      step();
      checks++;
      if (state !== 2'd1) begin
        errors++; $display("FAIL wait_state_%0d: state=%0d required 1", i, state);
      end
    end
    dmem_busy = 1'b0; #1;
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble} !== 7'b1101010) begin
      errors++; $display("FAIL wait_release: ctrl=%b required 1101010",
        {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble});
    end
    step();
    checks++;
    if (state !== 2'd0 || stall_count !== 16'd3) begin
      errors++; $display("FAIL wait_done: state=%0d stall=%0d required 0/3", state, stall_count);
    end
  endtask

  task automatic test_branch_during_wait();
    clear_counts();
    dmem_busy = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      mem_branch_taken = (c == 2); #1;
      checks++;
      if (state !== ((c == 1) ? 2'd0 : (c == 2) ? 2'd1 : 2'd2) || ifid_flush !== 1'b0 || pc_write !== 1'b0) begin
        errors++; $display("FAIL bwait_cycle_%0d: state=%0d ifid_flush=%b pc_write=%b", c, state, ifid_flush, pc_write);
      end
      step();
    end
    dmem_busy = 1'b0; mem_branch_taken = 1'b0; #1;
    checks++;
    if (state !== 2'd2 || {ifid_flush, idex_bubble, exmem_bubble, pc_write} !== 4'b1111) begin
      errors++; $display("FAIL bwait_flush: state=%0d flush/bub/bub/pc=%b required 2/1111", state,
        {ifid_flush, idex_bubble, exmem_bubble, pc_write});
    end
    step();
    checks++;
    if (state !== 2'd0 || ifid_flush !== 1'b0) begin
      errors++; $display("FAIL bwait_once: state=%0d ifid_flush=%b required 0/0", state, ifid_flush);
    end
    step();
    checks++;
    if (flush_count !== 16'd1 || stall_count !== 16'd4) begin
      errors++; $display("FAIL bwait_counts: flush=%0d stall=%0d required 1/4", flush_count, stall_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    dmem_busy = 1'b1; mem_branch_taken = 1'b1;
    step();
    mem_branch_taken = 1'b0; #1;
    checks++;
    if (state !== 2'd2) begin
      errors++; $display("FAIL rmid_enter: state=%0d required 2", state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; dmem_busy = 1'b0; #1;
    checks++;
    if (state !== 2'd0 || stall_count !== 16'd0 || flush_count !== 16'd0 || ifid_flush !== 1'b0) begin
      errors++; $display("FAIL rmid_reset: state=%0d stall=%0d flush=%0d ifid_flush=%b required 0/0/0/0",
        state, stall_count, flush_count, ifid_flush);
    end
    step();
    checks++;
    if (flush_count !== 16'd0) begin
      errors++; $display("FAIL rmid_noflush: flush=%0d required 0", flush_count);
    end
  endtask

  task automatic test_saturation();
    clear_counts();
    dmem_busy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (stall_count4 !== 4'd15 || stall_count !== 16'd20) begin
      errors++; $display("FAIL sat_hold: stall4=%0d stall16=%0d required 15/20", stall_count4, stall_count);
    end
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0; #1;
    checks++;
    if (stall_count4 !== 4'd0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL sat_clear: stall4=%0d stall16=%0d required 0/0", stall_count4, stall_count);
    end
    step();
    checks++;
    if (stall_count4 !== 4'd1) begin
      errors++; $display("FAIL sat_restart: stall4=%0d required 1", stall_count4);
    end
    dmem_busy = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    clear_counts();
    dmem_busy = 1'b1;
    step();
    dmem_busy = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
    checks++;
    if (state !== 2'd1 || {pc_write, ifid_write, idex_bubble} !== 3'b001) begin
      errors++; $display("FAIL b2b_wait_loaduse: state=%0d pc/ifid/bub=%b required 1/001", state,
        {pc_write, ifid_write, idex_bubble});
    end
    step();
    ex_mem_read = 1'b0; #1;
    checks++;
    if (state !== 2'd0 || stall_count !== 16'd2 || pc_write !== 1'b1) begin
      errors++; $display("FAIL b2b_done: state=%0d stall=%0d pc_write=%b required 0/2/1", state, stall_count, pc_write);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_during_wait();
    test_reset_mid_wait();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
